// File: rtl/reg_file_mp.sv
// Multi-port register file: one synchronous write port, two combinational read ports,
// and a hardware clear sequencer started by reset. Define REG_FILE_MP_BYPASS_EN for write-through forwarding.
module reg_file_mp #(
    parameter int                NUMRF   = 2,
    parameter int                SIZE    = 8,
    parameter logic [SIZE-1:0]   CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [NUMRF-1:0]  reg_in,
    input  logic [SIZE-1:0]   data_in,
    input  logic              rd_a,
    input  logic [NUMRF-1:0]  reg_a,
    output logic [SIZE-1:0]   data_a,
    input  logic              rd_b,
    input  logic [NUMRF-1:0]  reg_b,
    output logic [SIZE-1:0]   data_b,
    output logic              ready
);

    localparam int DEPTH = 1 << NUMRF;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state, next_state;
    logic [NUMRF-1:0]  clr_ptr, next_ptr;
    logic [SIZE-1:0]   regfile [DEPTH];

    logic              mem_we;
    logic [NUMRF-1:0]  mem_addr;
    logic [SIZE-1:0]   mem_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        state   <= next_state;
        clr_ptr <= next_ptr;
    end

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin
        next_state = state;
        next_ptr   = clr_ptr;
        mem_we     = 1'b0;
        mem_addr   = reg_in;
        mem_wdata  = data_in;
        if (rst) begin
            next_state = CLEAR;
            next_ptr   = '0;
        end else begin
            case (state)
                CLEAR: begin
                    // Clear has the write port; user writes are dropped until READY.
                    mem_we    = 1'b1;
                    mem_addr  = clr_ptr;
                    mem_wdata = CLR_VAL;
                    next_ptr  = clr_ptr + NUMRF'(1);
                    if (clr_ptr == {NUMRF{1'b1}})
                        next_state = READY;
                end
                READY: begin
                    mem_we = wr;
                end
                default: begin
                    next_state = CLEAR;
                    next_ptr   = '0;
                end
            endcase
        end
    end

    // NOTE: the array has no reset; the clear sequencer initialises it, keeping it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            regfile[mem_addr] <= mem_wdata;
    end

    assign ready = (state == READY);

    always_comb begin
        data_a = SIZE'({reg_a, reg_in});
        if (rd_a) begin
            if (!ready)
                data_a = CLR_VAL;
`ifdef REG_FILE_MP_BYPASS_EN
            else if (wr && (reg_a == reg_in))
                data_a = data_in;
`endif
            else
                data_a = regfile[reg_a];
        end
    end

    always_comb begin
        data_b = SIZE'({reg_b, reg_in});
        if (rd_b) begin
            if (!ready)
                data_b = CLR_VAL;
`ifdef REG_FILE_MP_BYPASS_EN
            else if (wr && (reg_b == reg_in))
                data_b = data_in;
`endif
            else
                data_b = regfile[reg_b];
        end
    end

endmodule
